alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational 16-bit ALU of the LC-3b datapath.
//  Captures operands on a valid/ready handshake, executes ADD/AND/NOT/XOR in one cycle,
//  runs shifts iteratively (1 bit/cycle) and adds an iterative shift-add MUL on op 7.
//  Registered result with registered N/Z/P, carry and overflow flags feeds the condition-code logic.
// PARAMETERS
//  WIDTH       16            datapath width, >= 4
//  SHAMT_W     4             shift-amount width; amounts >= WIDTH are legal
//  FAST_SHIFT  0             1: shifts complete in one cycle (barrel); 0: iterative
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         synchronous, active-high
//  in_valid   in   1         operand/op presented
//  in_ready   out  1         block can accept (high only in IDLE)
//  in1        in   WIDTH     operand A; shift/NOT source
//  in2        in   WIDTH     operand B
//  op         in   3         0 ADD,1 AND,2 NOT,3 XOR,4 LSHF,5 RSHFL,6 RSHFA,7 MUL
//  shift      in   SHAMT_W   shift amount (ops 4-6 only)
//  out_valid  out  1         result and flags valid
//  out_ready  in   1         consumer accepts result
//  out        out  WIDTH     result
//  zero       out  1         out == 0
//  negative   out  1         out[WIDTH-1]
//  positive   out  1         ~zero & ~negative (zero is NOT positive)
//  carry      out  1         ADD carry-out; 0 for all other ops
//  overflow   out  1         ADD signed overflow; 0 for all other ops
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  - FSM IDLE -> EXEC -> DONE -> IDLE. reset (any state, mid-op included) -> IDLE, out=0,
//    out_valid=0, zero=1, negative=0, positive=0, carry=0, overflow=0; in-flight op discarded.
//  - IDLE: in_ready=1; in_valid=1 at edge captures in1,in2,op,shift -> EXEC. in_valid ignored
//    in EXEC/DONE (no queuing, in_ready=0).
//  - EXEC per op: ADD/AND/NOT/XOR 1 cycle; shifts k'=min(shift,WIDTH) cycles (min 1; shift=0
//    returns in1 after 1 cycle); FAST_SHIFT=1 -> 1 cycle; MUL exactly WIDTH cycles.
//  - Latency = EXEC cycle count: out_valid rises on edge ending last EXEC cycle.
//  - Shifts: LSHF fills 0; RSHFL fills 0; RSHFA replicates sign. shift>=WIDTH -> 0,0,all-sign.
//  - MUL: unsigned shift-add, result = low WIDTH bits of in1*in2; upper half dropped, no flag.
//  - ADD: WIDTH-bit wrap-around sum; carry = bit WIDTH; overflow = operands same sign, sum differs.
//  - Flags update in same edge as out; held stable with out throughout DONE.
//  - DONE: out_valid=1; out/flags hold until out_valid & out_ready; then -> IDLE, out_valid=0
//    next cycle, out/flags retain last value. No back-to-back accept in the DONE->IDLE cycle.
//  - out_ready while not DONE has no effect.
// TESTING
//  1 reset then ADD 0x7FFF+0x0001 -> 1 cycle, out=0x8000, negative=1, overflow=1, carry=0
//  2 ADD 0xFFFF+0x0001 -> out=0x0000, zero=1, positive=0, carry=1, overflow=0
//  3 RSHFA 0x8010 shift=4 -> out_valid 4 cycles after accept, out=0xF801; RSHFL same -> 0x0801
//  4 LSHF 0x0001 shift=0 -> 1 cycle, out=0x0001; FAST_SHIFT=1, LSHF shift=15 -> 1 cycle, 0x8000
//  5 MUL 0x0123*0x0010 -> 16 cycles, out=0x1230, positive=1; hold out_ready=0 5 cycles, out stable
//  6 reset mid-MUL (cycle 8) -> next cycle IDLE, in_ready=1, out=0, zero=1; in_valid during EXEC ignored

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshaked operand/result bus for alu_seq: operand side (in_*) and result side (out_*, flags).
// The master drives operands and out_ready; the slave (the ALU) returns results and flags.
interface alu_seq_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shift;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               zero;
  logic               negative;
  logic               positive;
  logic               carry;
  logic               overflow;
  logic               busy;

  modport master (
    output in_valid, in1, in2, op, shift, out_ready,
    input  in_ready, out_valid, out, zero, negative, positive, carry, overflow, busy
  );

  modport slave (
    input  in_valid, in1, in2, op, shift, out_ready,
    output in_ready, out_valid, out, zero, negative, positive, carry, overflow, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/AND/NOT/XOR, iterative or barrel shifts,
// iterative shift-add MUL; registered result with N/Z/P, carry and overflow flags.
module alu_seq #(
  parameter int WIDTH      = 16,
  parameter int SHAMT_W    = 4,
  parameter int FAST_SHIFT = 0
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_AND, OP_NOT, OP_XOR, OP_LSHF, OP_RSHFL, OP_RSHFA, OP_MUL
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_out;
  logic [CNT_W-1:0] r_cnt, r_shamt;
  logic             r_out_valid, r_zero, r_negative, r_positive, r_carry, r_overflow;

  logic [CNT_W-1:0] w_shamt, w_cycles;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt, w_res;
  logic             w_carry, w_ovf;

  // Shift amounts at or beyond WIDTH saturate; they produce the same result as WIDTH.
  always_comb begin
    w_shamt = (32'(bus.shift) >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(bus.shift);
    case (op_t'(bus.op))
      OP_LSHF, OP_RSHFL, OP_RSHFA:
        w_cycles = ((FAST_SHIFT != 0) || (w_shamt == '0)) ? CNT_W'(1) : w_shamt;
      OP_MUL:  w_cycles = CNT_W'(WIDTH);
      default: w_cycles = CNT_W'(1);
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_acc_nxt = r_acc;
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    case (r_op)
      OP_ADD: begin
        {w_carry, w_res} = {1'b0, r_a} + {1'b0, r_b};
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_NOT: w_res = ~r_a;
      OP_XOR: w_res = r_a ^ r_b;
      OP_LSHF: begin
        if (FAST_SHIFT != 0) w_res = r_a << r_shamt;
        else                 w_res = (r_shamt != '0) ? {r_a[WIDTH-2:0], 1'b0} : r_a;
        w_a_nxt = w_res;
      end
      OP_RSHFL: begin
        if (FAST_SHIFT != 0) w_res = r_a >> r_shamt;
        else                 w_res = (r_shamt != '0) ? {1'b0, r_a[WIDTH-1:1]} : r_a;
        w_a_nxt = w_res;
      end
      OP_RSHFA: begin
        if (FAST_SHIFT != 0) w_res = $signed(r_a) >>> r_shamt;
        else                 w_res = (r_shamt != '0) ? {r_a[WIDTH-1], r_a[WIDTH-1:1]} : r_a;
        w_a_nxt = w_res;
      end
      OP_MUL: begin
        w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
        w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
        w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
        w_res     = w_acc_nxt;
      end
      default: w_res = '0;
    endcase
  end

  // NOTE: only control state and visible outputs are reset; operand registers are
  // always loaded on accept before they are read, so they need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b1;
      r_negative  <= 1'b0;
      r_positive  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a     <= bus.in1;
          r_b     <= bus.in2;
          r_acc   <= '0;
          r_op    <= op_t'(bus.op);
          r_shamt <= w_shamt;
          r_cnt   <= w_cycles;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_a   <= w_a_nxt;
          r_b   <= w_b_nxt;
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_out       <= w_res;
            r_zero      <= (w_res == '0);
            r_negative  <= w_res[WIDTH-1];
            r_positive  <= (w_res != '0) && !w_res[WIDTH-1];
            r_carry     <= w_carry;
            r_overflow  <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;
  assign bus.positive  = r_positive;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: iterative instance (bus0) and barrel-shift instance (bus1)
// share stimulus; sel picks which one handshakes and is observed.
module tb_alu_seq;
  logic        clk, reset, sel, in_valid, out_ready;
  logic [15:0] in1, in2;
  logic [2:0]  op;
  logic [3:0]  shift;
  int          n_checks = 0;
  int          n_errors = 0;

  alu_seq_if #(.WIDTH(16), .SHAMT_W(4)) bus0 ();
  alu_seq_if #(.WIDTH(16), .SHAMT_W(4)) bus1 ();

  alu_seq #(.WIDTH(16), .SHAMT_W(4), .FAST_SHIFT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  alu_seq #(.WIDTH(16), .SHAMT_W(4), .FAST_SHIFT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus0.out_ready = out_ready & ~sel;
  assign bus1.out_ready = out_ready & sel;
  assign bus0.in1 = in1;   assign bus1.in1 = in1;
  assign bus0.in2 = in2;   assign bus1.in2 = in2;
  assign bus0.op = op;     assign bus1.op = op;
  assign bus0.shift = shift; assign bus1.shift = shift;

  logic [15:0] o_out;
  logic o_valid, o_ready, o_busy, o_z, o_n, o_p, o_c, o_v;
  assign o_out   = sel ? bus1.out       : bus0.out;
  assign o_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign o_ready = sel ? bus1.in_ready  : bus0.in_ready;
  assign o_busy  = sel ? bus1.busy      : bus0.busy;
  assign o_z     = sel ? bus1.zero      : bus0.zero;
  assign o_n     = sel ? bus1.negative  : bus0.negative;
  assign o_p     = sel ? bus1.positive  : bus0.positive;
  assign o_c     = sel ? bus1.carry     : bus0.carry;
  assign o_v     = sel ? bus1.overflow  : bus0.overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, n, p, c, v);
    check({tag, ".zero"},     32'(o_z), 32'(z));
    check({tag, ".negative"}, 32'(o_n), 32'(n));
    check({tag, ".positive"}, 32'(o_p), 32'(p));
    check({tag, ".carry"},    32'(o_c), 32'(c));
    check({tag, ".overflow"}, 32'(o_v), 32'(v));
  endtask

  // Accept an op, then count edges until out_valid (bounded).
  task automatic run_op(input string tag, input logic [2:0] t_op, input logic [15:0] a, b,
                        input logic [3:0] sh, input int exp_lat, input logic [15:0] exp_out);
    int lat;
    op = t_op; in1 = a; in2 = b; shift = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, 32'(o_busy), 32'd1);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".out"}, 32'(o_out), 32'(exp_out));
  endtask

  task automatic release_result(input string tag, input logic [15:0] exp_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(o_valid), 32'd0);
    check({tag, ".in_ready"},   32'(o_ready), 32'd1);
    check({tag, ".retained"},   32'(o_out),   32'(exp_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; op = '0; shift = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", 32'(o_out), 32'h0);
    check("reset.out_valid", 32'(o_valid), 32'd0);
    check("reset.in_ready", 32'(o_ready), 32'd1);
    check("reset.busy", 32'(o_busy), 32'd0);
    check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 4'd0, 1, 16'h8000);
    check_flags("add_ovf", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    release_result("add_ovf", 16'h8000);

    run_op("add_carry", 3'd0, 16'hFFFF, 16'h0001, 4'd0, 1, 16'h0000);
    check_flags("add_carry", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    release_result("add_carry", 16'h0000);

    run_op("xor", 3'd3, 16'hAAAA, 16'h5555, 4'd0, 1, 16'hFFFF);
    check_flags("xor", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    release_result("xor", 16'hFFFF);

    run_op("and", 3'd1, 16'hF0F0, 16'h0FF0, 4'd0, 1, 16'h00F0);
    check_flags("and", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    release_result("and", 16'h00F0);

    run_op("not", 3'd2, 16'h00FF, 16'h1234, 4'd0, 1, 16'hFF00);
    release_result("not", 16'hFF00);

    run_op("rshfa", 3'd6, 16'h8010, 16'h0000, 4'd4, 4, 16'hF801);
    check_flags("rshfa", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    release_result("rshfa", 16'hF801);

    run_op("rshfl", 3'd5, 16'h8010, 16'h0000, 4'd4, 4, 16'h0801);
    check_flags("rshfl", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    release_result("rshfl", 16'h0801);

    run_op("lshf0", 3'd4, 16'h0001, 16'h0000, 4'd0, 1, 16'h0001);
    release_result("lshf0", 16'h0001);

    run_op("lshf15", 3'd4, 16'h0001, 16'h0000, 4'd15, 15, 16'h8000);
    release_result("lshf15", 16'h8000);

    sel = 1'b1;
    run_op("fast_lshf15", 3'd4, 16'h0001, 16'h0000, 4'd15, 1, 16'h8000);
    release_result("fast_lshf15", 16'h8000);
    run_op("fast_rshfa15", 3'd6, 16'h8000, 16'h0000, 4'd15, 1, 16'hFFFF);
    release_result("fast_rshfa15", 16'hFFFF);
    sel = 1'b0;

    run_op("mul", 3'd7, 16'h0123, 16'h0010, 4'd0, 16, 16'h1230);
    check_flags("mul", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("mul.hold_valid", 32'(o_valid), 32'd1);
      check("mul.hold_out", 32'(o_out), 32'h1230);
    end
    release_result("mul", 16'h1230);

    run_op("mul_wrap", 3'd7, 16'h1234, 16'h0100, 4'd0, 16, 16'h3400);
    release_result("mul_wrap", 16'h3400);

    // Operand changes presented while busy must not disturb the op in flight.
    op = 3'd5; in1 = 16'hF000; in2 = '0; shift = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 3'd0; in1 = 16'h0001; in2 = 16'h0001; shift = '0;
    for (int i = 0; i < 3; i++) begin
      check("ignore.in_ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ignore.valid", 32'(o_valid), 32'd1);
    check("ignore.out", 32'(o_out), 32'h00F0);
    release_result("ignore", 16'h00F0);

    op = 3'd7; in1 = 16'h0123; in2 = 16'h0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midmul.busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midmul.in_ready", 32'(o_ready), 32'd1);
    check("midmul.out", 32'(o_out), 32'h0);
    check("midmul.out_valid", 32'(o_valid), 32'd0);
    check_flags("midmul", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("midmul.no_result", 32'(o_valid), 32'd0);

    run_op("after_reset", 3'd0, 16'h0002, 16'h0003, 4'd0, 1, 16'h0005);
    release_result("after_reset", 16'h0005);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
